// File: rtl/aes_round_sequencer_if.sv
// Host/datapath handshake bundle for the AES round sequencer.
// The sequencer uses the slave modport. The host or testbench uses the master modport.
interface aes_round_sequencer_if #(
    parameter int ROUND_W = 4
);
    logic               start;
    logic [1:0]         keySize;
    logic               decrypt;
    logic               keyReady;
    logic               outAck;
    logic               busy;
    logic               cypherTextOn;
    logic               subByteOn;
    logic               shiftRowsOn;
    logic               mixColumnsOn;
    logic               keyExpansionOn;
    logic               addRoundKeyOn;
    logic               invMode;
    logic [ROUND_W-1:0] currentRound;
    logic [ROUND_W-1:0] roundKeyIndex;
    logic               done;
    logic               error;

    modport master (
        output start, keySize, decrypt, keyReady, outAck,
        input  busy, cypherTextOn, subByteOn, shiftRowsOn, mixColumnsOn,
               keyExpansionOn, addRoundKeyOn, invMode, currentRound,
               roundKeyIndex, done, error
    );

    modport slave (
        input  start, keySize, decrypt, keyReady, outAck,
        output busy, cypherTextOn, subByteOn, shiftRowsOn, mixColumnsOn,
               keyExpansionOn, addRoundKeyOn, invMode, currentRound,
               roundKeyIndex, done, error
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES-128/192/256 round controller: sequences datapath enables for encrypt and decrypt.
// It supports key-schedule stalls and a start/done handshake.
module aes_round_sequencer #(
    parameter int ROUND_W         = 4,
    parameter bit SUPPORT_DECRYPT = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    aes_round_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] nr_q, nr_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               inv_q, inv_d;
    logic               err_q, err_d;

    logic [ROUND_W-1:0] nr_sel;
    logic               start_ok;
    logic               active;
    logic               step;

    always_comb begin
        case (bus.keySize)
            2'b01:   nr_sel = ROUND_W'(12);
            2'b10:   nr_sel = ROUND_W'(14);
            default: nr_sel = ROUND_W'(10);
        endcase
    end

    assign start_ok = (bus.keySize != 2'b11) && (SUPPORT_DECRYPT || !bus.decrypt);

    // Next-state logic. A step only executes on a cycle with keyReady high.
    always_comb begin
        // NOTE: every _d gets a default first, so no latch can be inferred.
        state_d = state_q;
        nr_d    = nr_q;
        round_d = round_q;
        inv_d   = inv_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (start_ok) begin
                        state_d = S_INIT;
                        nr_d    = nr_sel;
                        inv_d   = bus.decrypt;
                        round_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_INIT: begin
                if (bus.keyReady) begin
                    state_d = S_ROUND;
                    round_d = ROUND_W'(1);
                end
            end
            S_ROUND: begin
                if (bus.keyReady) begin
                    round_d = round_q + ROUND_W'(1);
                    if (round_q == nr_q - ROUND_W'(1)) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                if (bus.keyReady) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.outAck) begin
                    if (bus.start && start_ok) begin
                        state_d = S_INIT;
                        nr_d    = nr_sel;
                        inv_d   = bus.decrypt;
                        round_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = bus.start;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            nr_q    <= ROUND_W'(10);
            round_q <= '0;
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking here, so every flop samples pre-edge values together.
            state_q <= state_d;
            nr_q    <= nr_d;
            round_q <= round_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
        end
    end

    // Enables decode from state. keyReady low masks them all, so a stall holds the datapath.
    assign active = (state_q == S_INIT) || (state_q == S_ROUND) || (state_q == S_FINAL);
    assign step   = active && bus.keyReady;

    assign bus.busy           = active;
    assign bus.cypherTextOn   = step && (state_q == S_INIT);
    assign bus.subByteOn      = step && (state_q != S_INIT);
    assign bus.shiftRowsOn    = step && (state_q != S_INIT);
    assign bus.mixColumnsOn   = step && (state_q == S_ROUND);
    assign bus.keyExpansionOn = step && !inv_q;
    assign bus.addRoundKeyOn  = step;
    assign bus.invMode        = inv_q;
    assign bus.currentRound   = round_q;
    assign bus.roundKeyIndex  = inv_q ? (nr_q - round_q) : round_q;
    assign bus.done           = (state_q == S_DONE);
    assign bus.error          = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer.
// It uses a step-count reference model, directed spec scenarios and a randomized soak.
module tb_aes_round_sequencer;

    localparam int ROUND_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_round_sequencer_if #(.ROUND_W(ROUND_W)) bus ();
    aes_round_sequencer_if #(.ROUND_W(ROUND_W)) bus_nd ();

    aes_round_sequencer #(.ROUND_W(ROUND_W), .SUPPORT_DECRYPT(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    aes_round_sequencer #(.ROUND_W(ROUND_W), .SUPPORT_DECRYPT(1'b0)) dut_nd (
        .clk(clk), .reset(reset), .bus(bus_nd)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model. m_k = -1 means idle; 0..Nr is the round step; Nr+1 means the result is waiting.
    int m_k   = -1;
    int m_nr  = 10;
    bit m_inv = 1'b0;
    bit m_err = 1'b0;

    function automatic int nr_of(input logic [1:0] ks);
        return (ks == 2'b00) ? 10 : (ks == 2'b01) ? 12 : 14;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k   <= -1;
            m_nr  <= 10;
            m_inv <= 1'b0;
            m_err <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_k < 0) begin
                if (bus.start) begin
                    if (bus.keySize != 2'b11) begin
                        m_k   <= 0;
                        m_nr  <= nr_of(bus.keySize);
                        m_inv <= bus.decrypt;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
            end else if (m_k <= m_nr) begin
                if (bus.keyReady) m_k <= m_k + 1;
            end else if (bus.outAck) begin
                if (bus.start && bus.keySize != 2'b11) begin
                    m_k   <= 0;
                    m_nr  <= nr_of(bus.keySize);
                    m_inv <= bus.decrypt;
                end else begin
                    m_k   <= -1;
                    m_err <= bus.start;
                end
            end
        end
    end

    // Compare process: outputs are checked every cycle on the falling edge.
    always @(negedge clk) begin
        bit busy_e, step_e, done_e;
        int rnd;
        if (!reset) begin
            busy_e = (m_k >= 0) && (m_k <= m_nr);
            step_e = busy_e && bus.keyReady;
            done_e = (m_k == m_nr + 1);
            check("busy", bus.busy, busy_e);
            check("enables",
                  {bus.cypherTextOn, bus.subByteOn, bus.shiftRowsOn, bus.mixColumnsOn,
                   bus.keyExpansionOn, bus.addRoundKeyOn},
                  {step_e && m_k == 0, step_e && m_k >= 1, step_e && m_k >= 1,
                   step_e && m_k >= 1 && m_k < m_nr, step_e && !m_inv, step_e});
            check("done", bus.done, done_e);
            check("error", bus.error, m_err);
            check("invMode", bus.invMode, m_inv);
            if (m_k >= 0) begin
                rnd = done_e ? m_nr : m_k;
                check("currentRound", bus.currentRound, rnd);
                check("roundKeyIndex", bus.roundKeyIndex, m_inv ? m_nr - rnd : rnd);
            end
        end
    end

    task automatic launch(input logic [1:0] ks, input bit dec, input bit ack);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.keySize  = ks;
        bus.decrypt  = dec;
        bus.outAck   = ack;
        bus.keyReady = 1'b1;
    endtask

    // Runs one block that was launched on the previous edge. It returns the first done cycle and per-cycle observations.
    task automatic run_loop(input int stall_c, input int stall_len, input int stall_round,
                            output int done_c, output int busy_n, output int ke_n,
                            output int rki_first, output int rki_last,
                            output logic [31:0] cy_mask, output logic [31:0] mix_mask);
        done_c = -1; busy_n = 0; ke_n = 0; rki_first = -1; rki_last = -1;
        cy_mask = '0; mix_mask = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus.start    = 1'b0;
            bus.outAck   = 1'b0;
            bus.keyReady = !(stall_len > 0 && c >= stall_c && c < stall_c + stall_len);
            @(negedge clk);
            if (c < 32) begin
                cy_mask[c]  = bus.cypherTextOn;
                mix_mask[c] = bus.mixColumnsOn;
            end
            if (bus.busy) begin
                busy_n++;
                if (rki_first < 0) rki_first = int'(bus.roundKeyIndex);
                rki_last = int'(bus.roundKeyIndex);
                if (bus.keyExpansionOn) ke_n++;
            end
            if (!bus.keyReady) begin
                check("stall_enables",
                      {bus.cypherTextOn, bus.subByteOn, bus.shiftRowsOn, bus.mixColumnsOn,
                       bus.keyExpansionOn, bus.addRoundKeyOn}, 0);
                check("stall_round", bus.currentRound, stall_round);
                check("stall_busy", bus.busy, 1);
            end
            if (bus.done) begin
                done_c = c;
                break;
            end
        end
    endtask

    task automatic ack_done();
        @(posedge clk); #1;
        bus.outAck = 1'b1;
        @(posedge clk); #1;
        bus.outAck = 1'b0;
        @(negedge clk);
        check("ack_release_done", bus.done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc, bn, ken, rf, rl, blocks;
        logic [31:0] cym, mxm;
        logic prev_done;

        bus.start = 1'b0; bus.keySize = 2'b00; bus.decrypt = 1'b0;
        bus.keyReady = 1'b1; bus.outAck = 1'b0;
        bus_nd.start = 1'b0; bus_nd.keySize = 2'b00; bus_nd.decrypt = 1'b0;
        bus_nd.keyReady = 1'b1; bus_nd.outAck = 1'b0;
        reset = 1'b1;
        #12;
        check("reset_outputs",
              {bus.busy, bus.cypherTextOn, bus.subByteOn, bus.shiftRowsOn, bus.mixColumnsOn,
               bus.keyExpansionOn, bus.addRoundKeyOn, bus.invMode, bus.done, bus.error,
               bus.currentRound, bus.roundKeyIndex}, 0);
        @(negedge clk); #2;
        reset = 1'b0;

        // AES-128 encrypt from IDLE
        launch(2'b00, 1'b0, 1'b0);
        run_loop(0, 0, 0, dc, bn, ken, rf, rl, cym, mxm);
        check("t1_done_cycle", dc, 12);
        check("t1_cypher_mask", cym, 32'h0000_0002);
        check("t1_mix_mask", mxm, 32'h0000_07FC);
        check("t1_rki_first", rf, 0);
        check("t1_rki_last", rl, 10);
        check("t1_keyexp_cycles", ken, 11);

        // Back-to-back AES-128 block launched from DONE
        launch(2'b00, 1'b0, 1'b1);
        run_loop(0, 0, 0, dc, bn, ken, rf, rl, cym, mxm);
        check("t5_init_no_gap", cym, 32'h0000_0002);
        check("t5_done_cycle", dc, 12);
        ack_done();

        // AES-256 decrypt
        launch(2'b10, 1'b1, 1'b0);
        run_loop(0, 0, 0, dc, bn, ken, rf, rl, cym, mxm);
        check("t2_done_cycle", dc, 16);
        check("t2_busy_cycles", bn, 15);
        check("t2_keyexp_cycles", ken, 0);
        check("t2_rki_first", rf, 14);
        check("t2_rki_last", rl, 0);
        check("t2_invMode", bus.invMode, 1);
        ack_done();

        // AES-192 encrypt with a 3-cycle key stall at round 5
        launch(2'b01, 1'b0, 1'b0);
        run_loop(6, 3, 5, dc, bn, ken, rf, rl, cym, mxm);
        check("t3_done_cycle", dc, 17);
        check("t3_busy_cycles", bn, 16);
        ack_done();

        // Rejected starts: invalid key size, and decrypt on the encrypt-only build
        @(posedge clk); #1;
        bus.start = 1'b1; bus.keySize = 2'b11; bus.decrypt = 1'b0;
        bus_nd.start = 1'b1; bus_nd.keySize = 2'b00; bus_nd.decrypt = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus_nd.start = 1'b0; bus_nd.decrypt = 1'b0;
        @(negedge clk);
        check("t4_error_pulse", bus.error, 1);
        check("t4_error_busy", bus.busy, 0);
        check("t4_nd_error_pulse", bus_nd.error, 1);
        check("t4_nd_busy", bus_nd.busy, 0);
        @(negedge clk);
        check("t4_error_cleared", bus.error, 0);
        check("t4_still_idle", bus.busy, 0);
        check("t4_nd_error_cleared", bus_nd.error, 0);
        @(posedge clk); #1;
        bus_nd.start = 1'b1;
        @(posedge clk); #1;
        bus_nd.start = 1'b0;
        @(negedge clk);
        check("t4_nd_encrypt_accepted", {bus_nd.busy, bus_nd.error, bus_nd.cypherTextOn}, 3'b101);

        // Asynchronous reset in the middle of round 6
        launch(2'b00, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        @(negedge clk);
        check("t6_round_before_reset", bus.currentRound, 6);
        #2;
        reset = 1'b1;
        #1;
        check("t6_outputs_cleared",
              {bus.busy, bus.cypherTextOn, bus.subByteOn, bus.shiftRowsOn, bus.mixColumnsOn,
               bus.keyExpansionOn, bus.addRoundKeyOn, bus.invMode, bus.done, bus.error,
               bus.currentRound, bus.roundKeyIndex}, 0);
        @(negedge clk); #2;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t6_no_done_after_reset", {bus.done, bus.busy}, 0);
        end
        launch(2'b00, 1'b0, 1'b0);
        run_loop(0, 0, 0, dc, bn, ken, rf, rl, cym, mxm);
        check("t6_full_block_after_reset", dc, 12);
        ack_done();

        // Randomized soak against the model
        blocks = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.keySize  = 2'($urandom_range(0, 3));
            bus.decrypt  = 1'($urandom_range(0, 1));
            bus.keyReady = ($urandom_range(0, 4) != 0);
            bus.outAck   = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (bus.done && !prev_done) blocks++;
            prev_done = bus.done;
        end
        check("random_blocks_completed", blocks > 20, 1);

        @(posedge clk); #1;
        bus.start = 1'b0; bus.outAck = 1'b0; bus.keyReady = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
